// File: rtl/button_debounce_bit.sv
// One button channel: two-flop synchronizer, debounce counter, hold counter
// and the registered press/release pulses derived from the debounced level.
// i_pin is already polarity-corrected by the parent (1 = pressed).
module button_debounce_bit #(
    parameter int DEBOUNCE = 50000,
    parameter int HOLD     = 25000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_held
);

    localparam int DB_W   = $clog2(DEBOUNCE);
    localparam int HOLD_W = $clog2(HOLD + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD);

    logic [1:0]        sync_q, sync_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              btn_q, btn_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              held_q, held_d;

    // Next-state: synchronizer shift, debounce acceptance, saturating hold count.
    always_comb begin
        sync_d     = {sync_q[0], i_pin};
        db_cnt_d   = db_cnt_q;
        btn_d      = btn_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;

        // Any cycle where the synchronized pin agrees with the accepted level
        // restarts the count, so bounces shorter than DEBOUNCE are dropped.
        if (sync_q[1] == btn_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DB_LAST) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end else begin
            db_cnt_d  = '0;
            btn_d     = sync_q[1];
            press_d   = sync_q[1];
            release_d = ~sync_q[1];
        end

        // Counting starts the cycle after o_btn rises and clears on the same
        // edge that o_btn falls; saturation prevents wrap on long presses.
        if (!btn_d) begin
            hold_cnt_d = '0;
        end else if (btn_q && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        held_d = (hold_cnt_d == HOLD_MAX);
    end

    // State registers; reset returns everything to the not-pressed condition.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q     <= 2'b00;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            btn_q      <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            btn_q      <= btn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            held_q     <= held_d;
        end
    end

    assign o_btn     = btn_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_held    = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the SPIO block: pin polarity correction, one
// debounce channel per button, and a registered any-press interrupt.
module button_conditioner #(
    parameter int NBTN       = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int DEBOUNCE   = 50000,
    parameter int HOLD       = 25000000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_held,
    output logic            o_int
);

    logic [NBTN-1:0] pin_act;
    logic            int_q, int_d;

    // Inversion sits in front of the first synchronizer flop, so reset
    // (flops cleared to 0) always means not-pressed regardless of polarity.
    assign pin_act = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        button_debounce_bit #(
            .DEBOUNCE (DEBOUNCE),
            .HOLD     (HOLD)
        ) u_bit (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_pin     (pin_act[g]),
            .o_btn     (o_btn[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_held    (o_held[g])
        );
    end

    // Interrupt is any press, delayed one clock.
    always_comb begin
        int_d = |o_press;
    end

    // Interrupt register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            int_q <= 1'b0;
        end else begin
            int_q <= int_d;
        end
    end

    assign o_int = int_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, HOLD=16, NBTN=2,
// active-low pins. Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, so "tick k" shows the state after edge k.
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] btn_pin;
    logic [1:0] btn;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] held;
    logic       intr;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .NBTN       (2),
        .ACTIVE_LOW (1),
        .DEBOUNCE   (4),
        .HOLD       (16)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_btn     (btn_pin),
        .o_btn     (btn),
        .o_press   (press),
        .o_release (rel),
        .o_held    (held),
        .o_int     (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        btn_pin = 2'b11;
        rst     = 1'b1;
        tick();
        tick();
        checks++;
        if ({btn, press, rel, held, intr} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {btn, press, rel, held, intr});
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({btn, press, rel, held, intr} !== 9'b0) begin
                errors++;
                $display("FAIL reset_deassert_t%0d: got %b expected 0", i, {btn, press, rel, held, intr});
            end
        end
    endtask

    task automatic test_clean_press();
        btn_pin[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (btn !== 2'b00 || press !== 2'b00) begin
                errors++;
                $display("FAIL press_early_t%0d: btn=%b press=%b expected 00/00", i, btn, press);
            end
        end
        tick();
        checks++;
        if (btn !== 2'b01 || press !== 2'b01 || intr !== 1'b0) begin
            errors++;
            $display("FAIL press_t6: btn=%b press=%b int=%b expected 01/01/0", btn, press, intr);
        end
        tick();
        checks++;
        if (press !== 2'b00 || intr !== 1'b1 || btn !== 2'b01) begin
            errors++;
            $display("FAIL press_t7: btn=%b press=%b int=%b expected 01/00/1", btn, press, intr);
        end
        // Short press: release now, well before the hold threshold.
        btn_pin[0] = 1'b1;
        tick();
        checks++;
        if (intr !== 1'b0) begin
            errors++;
            $display("FAIL int_single: int=%b expected 0", intr);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            checks++;
            if (btn !== 2'b01 || rel !== 2'b00 || held !== 2'b00) begin
                errors++;
                $display("FAIL release_early_t%0d: btn=%b rel=%b held=%b expected 01/00/00", i, btn, rel, held);
            end
        end
        tick();
        checks++;
        if (btn !== 2'b00 || rel !== 2'b01 || press !== 2'b00) begin
            errors++;
            $display("FAIL release_t6: btn=%b rel=%b press=%b expected 00/01/00", btn, rel, press);
        end
        tick();
        checks++;
        if (rel !== 2'b00 || intr !== 1'b0) begin
            errors++;
            $display("FAIL release_t7: rel=%b int=%b expected 00/0", rel, intr);
        end
    endtask

    // Three-cycle pulses are one short of the four needed for acceptance.
    task automatic test_bounce();
        int npress;
        for (int i = 0; i < 30; i++) begin
            btn_pin[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (btn !== 2'b00 || press !== 2'b00 || rel !== 2'b00 || intr !== 1'b0) begin
                errors++;
                $display("FAIL bounce_t%0d: btn=%b press=%b rel=%b int=%b expected all 0", i, btn, press, rel, intr);
            end
        end
        btn_pin[0] = 1'b0;
        npress = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (press[0]) npress++;
        end
        checks++;
        if (press !== 2'b01 || btn !== 2'b01 || npress != 1) begin
            errors++;
            $display("FAIL settle_press: press=%b btn=%b count=%0d expected 01/01/1", press, btn, npress);
        end
    endtask

    // Continues from the press accepted at the end of test_bounce.
    task automatic test_hold();
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (held !== 2'b00) begin
                errors++;
                $display("FAIL hold_early_t%0d: held=%b expected 00", i, held);
            end
        end
        tick();
        checks++;
        if (held !== 2'b01) begin
            errors++;
            $display("FAIL hold_t16: held=%b expected 01", held);
        end
        for (int i = 1; i <= 10; i++) tick();
        checks++;
        if (held !== 2'b01 || btn !== 2'b01) begin
            errors++;
            $display("FAIL hold_stays: held=%b btn=%b expected 01/01", held, btn);
        end
        btn_pin[0] = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        checks++;
        if (held !== 2'b01 || btn !== 2'b01 || rel !== 2'b00) begin
            errors++;
            $display("FAIL hold_release_early: held=%b btn=%b rel=%b expected 01/01/00", held, btn, rel);
        end
        tick();
        checks++;
        if (held !== 2'b00 || btn !== 2'b00 || rel !== 2'b01) begin
            errors++;
            $display("FAIL hold_release: held=%b btn=%b rel=%b expected 00/00/01", held, btn, rel);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        btn_pin = 2'b00;
        for (int i = 1; i <= 5; i++) tick();
        checks++;
        if (press !== 2'b00 || btn !== 2'b00) begin
            errors++;
            $display("FAIL simul_early: press=%b btn=%b expected 00/00", press, btn);
        end
        tick();
        checks++;
        if (press !== 2'b11 || btn !== 2'b11 || intr !== 1'b0) begin
            errors++;
            $display("FAIL simul_press: press=%b btn=%b int=%b expected 11/11/0", press, btn, intr);
        end
        tick();
        checks++;
        if (press !== 2'b00 || intr !== 1'b1) begin
            errors++;
            $display("FAIL simul_int: press=%b int=%b expected 00/1", press, intr);
        end
        tick();
        checks++;
        if (intr !== 1'b0) begin
            errors++;
            $display("FAIL simul_int_single: int=%b expected 0", intr);
        end
    endtask

    // Pins stay low from test_simultaneous; the hold count has run 2 cycles.
    task automatic test_reset_mid_hold();
        for (int i = 3; i <= 16; i++) tick();
        checks++;
        if (held !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_held: held=%b expected 11", held);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({btn, press, rel, held, intr} !== 9'b0) begin
            errors++;
            $display("FAIL reset_async_clear: got %b expected 0", {btn, press, rel, held, intr});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (press !== 2'b00 || btn !== 2'b00) begin
                errors++;
                $display("FAIL repress_early_t%0d: press=%b btn=%b expected 00/00", i, press, btn);
            end
        end
        tick();
        checks++;
        if (press !== 2'b11 || btn !== 2'b11) begin
            errors++;
            $display("FAIL repress: press=%b btn=%b expected 11/11", press, btn);
        end
        tick();
        checks++;
        if (intr !== 1'b1 || held !== 2'b00) begin
            errors++;
            $display("FAIL repress_int: int=%b held=%b expected 1/00", intr, held);
        end
        for (int i = 2; i <= 15; i++) tick();
        checks++;
        if (held !== 2'b00) begin
            errors++;
            $display("FAIL rehold_early: held=%b expected 00", held);
        end
        tick();
        checks++;
        if (held !== 2'b11) begin
            errors++;
            $display("FAIL rehold: held=%b expected 11", held);
        end
    endtask

    initial begin
        btn_pin = 2'b11;
        rst     = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_simultaneous();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
